id_stage_param: RTL and testbench

- Parametrised instruction-decode stage plus ID/EX pipeline register for the 16-bit-instruction pipeline.
- Contains an 8-entry register file of DATA_W-bit registers with optional write-through bypass, immediate extension to DATA_W, and destination-register select.
- The ID/EX register supports hold (freeze), flush (squash) and stall (bubble) with fixed priority.
- Sits between the IF/ID register and the execute stage; write-back arrives from MEM/WB.

---
 rtl/id_stage_param_if.sv | 66 ++++++
 rtl/id_stage_param.sv | 121 ++++++++++++
 tb/tb_id_stage_param.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_param_if.sv
// ID stage bus: IF/ID-side inputs, MEM/WB write-back port and ID/EX outputs.
// The master side (upstream pipeline / bench) drives the *_in, control and
// write-back fields and observes the registered outputs; the slave side is
// the decode stage itself.
//
// Handshake: valid_out qualifies the ID/EX contents (1 = real instruction,
// 0 = bubble/squash). There is no ready signal; downstream back-pressure is
// expressed through hold, which freezes the ID/EX register (valid_out
// included) for as long as it is asserted.
interface id_stage_param_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 15
);
  // IF/ID side
  logic [15:0]       instr_in;
  logic [DATA_W-1:0] pc2_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              reg_write_in;
  logic              mem_write_in;
  logic              mem_read_in;
  logic              halt_in;
  logic [1:0]        reg_dst;
  logic [1:0]        imm_size;
  logic              zero_ex;
  // pipeline control
  logic              stall;
  logic              flush;
  logic              hold;
  // write-back from MEM/WB
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  // ID/EX register outputs
  logic [DATA_W-1:0] pc2_out;
  logic [DATA_W-1:0] rd1_out;
  logic [DATA_W-1:0] rd2_out;
  logic [DATA_W-1:0] imm_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [2:0]        rs_addr_out;
  logic [2:0]        rt_addr_out;
  logic [2:0]        wr_addr_out;
  logic              reg_write_out;
  logic              mem_write_out;
  logic              mem_read_out;
  logic              halt_out;
  logic              valid_out;
  logic              err;

  modport master (
    output instr_in, pc2_in, ctrl_in, reg_write_in, mem_write_in, mem_read_in,
           halt_in, reg_dst, imm_size, zero_ex, stall, flush, hold,
           wb_en, wb_addr, wb_data,
    input  pc2_out, rd1_out, rd2_out, imm_out, ctrl_out, rs_addr_out,
           rt_addr_out, wr_addr_out, reg_write_out, mem_write_out,
           mem_read_out, halt_out, valid_out, err
  );

  modport slave (
    input  instr_in, pc2_in, ctrl_in, reg_write_in, mem_write_in, mem_read_in,
           halt_in, reg_dst, imm_size, zero_ex, stall, flush, hold,
           wb_en, wb_addr, wb_data,
    output pc2_out, rd1_out, rd2_out, imm_out, ctrl_out, rs_addr_out,
           rt_addr_out, wr_addr_out, reg_write_out, mem_write_out,
           mem_read_out, halt_out, valid_out, err
  );
endinterface

// File: rtl/id_stage_param.sv
// Instruction-decode stage with ID/EX pipeline register.
// 8 x DATA_W register file (no hardwired zero), immediate extension,
// destination select, and an ID/EX register with hold > flush > stall
// priority. Optional macro ID_RF_BYPASS_EN turns on write-before-read
// bypass from the write-back port to both read ports.
// The interface instance must be built with the same DATA_W/CTRL_W.
module id_stage_param #(
  parameter int DATA_W   = 16,
  parameter int CTRL_W   = 15,
  parameter int LINK_REG = 7
) (
  input logic             clk,
  input logic             rst,
  id_stage_param_if.slave bus
);

  localparam logic [2:0] LINK_IDX = 3'(LINK_REG);

  logic [DATA_W-1:0] rf [8];
  logic [2:0]        rs_addr;
  logic [2:0]        rt_addr;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] imm_ext;
  logic [2:0]        wr_addr;
  logic              live;

  assign rs_addr = bus.instr_in[10:8];
  assign rt_addr = bus.instr_in[7:5];

  // An instruction becomes real in EX only when neither squashed nor bubbled.
  assign live = ~(bus.flush | bus.stall);

  // Register file write port; writes proceed even while ID/EX is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.wb_en) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    rd1 = rf[rs_addr];
    rd2 = rf[rt_addr];
`ifdef ID_RF_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == rs_addr)) rd1 = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == rt_addr)) rd2 = bus.wb_data;
`endif
  end

  // Immediate field select and sign/zero extension; illegal size gives zero.
  always_comb begin
    imm_ext = '0;
    case (bus.imm_size)
      2'b00: imm_ext = bus.zero_ex ? {{(DATA_W-5){1'b0}}, bus.instr_in[4:0]}
                                   : {{(DATA_W-5){bus.instr_in[4]}}, bus.instr_in[4:0]};
      2'b01: imm_ext = bus.zero_ex ? {{(DATA_W-8){1'b0}}, bus.instr_in[7:0]}
                                   : {{(DATA_W-8){bus.instr_in[7]}}, bus.instr_in[7:0]};
      2'b10: imm_ext = bus.zero_ex ? {{(DATA_W-11){1'b0}}, bus.instr_in[10:0]}
                                   : {{(DATA_W-11){bus.instr_in[10]}}, bus.instr_in[10:0]};
      default: imm_ext = '0;
    endcase
  end

  // Destination register select.
  always_comb begin
    wr_addr = '0;
    case (bus.reg_dst)
      2'b00:   wr_addr = bus.instr_in[7:5];
      2'b01:   wr_addr = bus.instr_in[4:2];
      2'b10:   wr_addr = bus.instr_in[10:8];
      default: wr_addr = LINK_IDX;
    endcase
  end

  // ID/EX register: hold freezes everything; flush/stall load the data
  // fields but clear valid and every side-effect control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pc2_out       <= '0;
      bus.rd1_out       <= '0;
      bus.rd2_out       <= '0;
      bus.imm_out       <= '0;
      bus.ctrl_out      <= '0;
      bus.rs_addr_out   <= '0;
      bus.rt_addr_out   <= '0;
      bus.wr_addr_out   <= '0;
      bus.reg_write_out <= 1'b0;
      bus.mem_write_out <= 1'b0;
      bus.mem_read_out  <= 1'b0;
      bus.halt_out      <= 1'b0;
      bus.valid_out     <= 1'b0;
    end else if (!bus.hold) begin
      bus.pc2_out       <= bus.pc2_in;
      bus.rd1_out       <= rd1;
      bus.rd2_out       <= rd2;
      bus.imm_out       <= imm_ext;
      bus.ctrl_out      <= bus.ctrl_in;
      bus.rs_addr_out   <= rs_addr;
      bus.rt_addr_out   <= rt_addr;
      bus.wr_addr_out   <= wr_addr;
      bus.reg_write_out <= bus.reg_write_in & live;
      bus.mem_write_out <= bus.mem_write_in & live;
      bus.mem_read_out  <= bus.mem_read_in & live;
      bus.halt_out      <= bus.halt_in & live;
      bus.valid_out     <= live;
    end
  end

  // Sticky error: an illegal immediate size reached a loading, live slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.err <= 1'b0;
    end else if (!bus.hold && live && (bus.imm_size == 2'b11)) begin
      bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param: directed steps from the test plan followed by a
// randomized run, all checked against a behavioural model of the stage.
module tb_id_stage_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_param_if #(.DATA_W(16), .CTRL_W(15)) bus ();
  id_stage_param_if #(.DATA_W(32), .CTRL_W(15)) bus32 ();

  id_stage_param #(.DATA_W(16), .CTRL_W(15), .LINK_REG(7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  id_stage_param #(.DATA_W(32), .CTRL_W(15), .LINK_REG(7)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  typedef struct {
    logic [63:0] pc2, rd1, rd2, imm;
    logic [14:0] ctrl;
    logic [2:0]  rs, rt, wr;
    logic        rw, mw, mr, halt, valid, err;
  } exp_t;

  exp_t        cur;
  exp_t        snap;
  exp_t        exp_q[$];
  logic [15:0] m_rf[8];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [63:0] imm_model(input logic [15:0] instr, input logic [1:0] size,
                                            input logic zx, input int dw);
    int     w;
    longint v;
    case (size)
      2'd0: w = 5;
      2'd1: w = 8;
      2'd2: w = 11;
      default: return 64'd0;
    endcase
    v = longint'(instr) & ((longint'(1) << w) - 1);
    if (!zx && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return 64'(v) & ((64'd1 << dw) - 64'd1);
  endfunction

  function automatic logic [2:0] dst_model(input logic [15:0] instr, input logic [1:0] sel);
    case (sel)
      2'd0: return instr[7:5];
      2'd1: return instr[4:2];
      2'd2: return instr[10:8];
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [15:0] rf_read(input logic [2:0] a);
`ifdef ID_RF_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic exp_t predict();
    exp_t n;
    logic live;
    n = cur;
    if (!bus.hold) begin
      live    = !(bus.flush || bus.stall);
      n.pc2   = 64'(bus.pc2_in);
      n.rd1   = 64'(rf_read(bus.instr_in[10:8]));
      n.rd2   = 64'(rf_read(bus.instr_in[7:5]));
      n.imm   = imm_model(bus.instr_in, bus.imm_size, bus.zero_ex, 16);
      n.ctrl  = bus.ctrl_in;
      n.rs    = bus.instr_in[10:8];
      n.rt    = bus.instr_in[7:5];
      n.wr    = dst_model(bus.instr_in, bus.reg_dst);
      n.rw    = bus.reg_write_in && live;
      n.mw    = bus.mem_write_in && live;
      n.mr    = bus.mem_read_in && live;
      n.halt  = bus.halt_in && live;
      n.valid = live;
      if (live && bus.imm_size == 2'b11) n.err = 1'b1;
    end
    return n;
  endfunction

  task automatic model_reset();
    cur = '{default: '0};
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc2"},   64'(bus.pc2_out),       cur.pc2);
    chk({tag, ".rd1"},   64'(bus.rd1_out),       cur.rd1);
    chk({tag, ".rd2"},   64'(bus.rd2_out),       cur.rd2);
    chk({tag, ".imm"},   64'(bus.imm_out),       cur.imm);
    chk({tag, ".ctrl"},  64'(bus.ctrl_out),      64'(cur.ctrl));
    chk({tag, ".rs"},    64'(bus.rs_addr_out),   64'(cur.rs));
    chk({tag, ".rt"},    64'(bus.rt_addr_out),   64'(cur.rt));
    chk({tag, ".wr"},    64'(bus.wr_addr_out),   64'(cur.wr));
    chk({tag, ".rw"},    64'(bus.reg_write_out), 64'(cur.rw));
    chk({tag, ".mw"},    64'(bus.mem_write_out), 64'(cur.mw));
    chk({tag, ".mr"},    64'(bus.mem_read_out),  64'(cur.mr));
    chk({tag, ".halt"},  64'(bus.halt_out),      64'(cur.halt));
    chk({tag, ".valid"}, 64'(bus.valid_out),     64'(cur.valid));
    chk({tag, ".err"},   64'(bus.err),           64'(cur.err));
  endtask

  // One clock: predict from current inputs, sample #1 after the edge.
  task automatic cycle(input string tag);
    exp_q.push_back(predict());
    @(posedge clk);
    #1;
    if (bus.wb_en) m_rf[bus.wb_addr] = bus.wb_data;
    cur = exp_q.pop_front();
    check_all(tag);
  endtask

  task automatic set_idle();
    bus.instr_in = '0; bus.pc2_in = '0; bus.ctrl_in = '0;
    bus.reg_write_in = 0; bus.mem_write_in = 0; bus.mem_read_in = 0; bus.halt_in = 0;
    bus.reg_dst = '0; bus.imm_size = '0; bus.zero_ex = 0;
    bus.stall = 0; bus.flush = 0; bus.hold = 0;
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus32.instr_in = '0; bus32.pc2_in = '0; bus32.ctrl_in = '0;
    bus32.reg_write_in = 0; bus32.mem_write_in = 0; bus32.mem_read_in = 0; bus32.halt_in = 0;
    bus32.reg_dst = '0; bus32.imm_size = '0; bus32.zero_ex = 0;
    bus32.stall = 0; bus32.flush = 0; bus32.hold = 0;
    bus32.wb_en = 0; bus32.wb_addr = '0; bus32.wb_data = '0;
  endtask

  task automatic rand_data();
    bus.instr_in     = 16'($urandom);
    bus.pc2_in       = 16'($urandom);
    bus.ctrl_in      = 15'($urandom);
    bus.reg_write_in = 1'($urandom);
    bus.mem_write_in = 1'($urandom);
    bus.mem_read_in  = 1'($urandom);
    bus.halt_in      = 1'($urandom);
    bus.reg_dst      = 2'($urandom);
    bus.imm_size     = 2'($urandom_range(0, 2));
    bus.zero_ex      = 1'($urandom);
    bus.wb_en        = 1'($urandom);
    bus.wb_addr      = 3'($urandom);
    bus.wb_data      = 16'($urandom);
  endtask

  initial begin
    model_reset();
    set_idle();

    // Reset state
    #2 rst = 1'b0;
    #1 check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_held");
    rst = 1'b1;

    // A live instruction so that valid/reg_write are set before a mid-stream reset
    bus.instr_in = 16'h1234; bus.pc2_in = 16'h0042; bus.reg_write_in = 1;
    bus.wb_en = 1; bus.wb_addr = 3'd2; bus.wb_data = 16'h1111;
    cycle("live");
    chk("live.valid_set", 64'(bus.valid_out), 64'd1);
    chk("live.rw_set", 64'(bus.reg_write_out), 64'd1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("async_reset");
    chk("async_reset.valid", 64'(bus.valid_out), 64'd0);
    #1 rst = 1'b1;
    set_idle();

    // Every register reads zero after reset
    for (int i = 0; i < 8; i++) begin
      bus.instr_in = 16'(i << 8) | 16'(i << 5);
      cycle("rf_zero");
      chk("rf_zero.rd1", 64'(bus.rd1_out), 64'd0);
    end

    // Write-back forwarding
    bus.wb_en = 1; bus.wb_addr = 3'd3; bus.wb_data = 16'hBEEF; bus.instr_in = 16'h0300;
    cycle("bypass");
`ifdef ID_RF_BYPASS_EN
    chk("bypass.same_edge", 64'(bus.rd1_out), 64'hBEEF);
`else
    chk("bypass.same_edge", 64'(bus.rd1_out), 64'h0000);
`endif
    bus.wb_en = 0;
    cycle("bypass2");
    chk("bypass.next_edge", 64'(bus.rd1_out), 64'hBEEF);

    // Immediate extension
    bus.instr_in = 16'h001F; bus.imm_size = 2'b00; bus.zero_ex = 0;
    bus32.instr_in = 16'h001F; bus32.imm_size = 2'b00; bus32.zero_ex = 0;
    cycle("imm_sx5");
    chk("imm_sx5.val", 64'(bus.imm_out), 64'hFFFF);
    chk("imm32_sx5.val", 64'(bus32.imm_out), 64'hFFFF_FFFF);
    bus.zero_ex = 1; bus32.zero_ex = 1;
    cycle("imm_zx5");
    chk("imm_zx5.val", 64'(bus.imm_out), 64'h001F);
    chk("imm32_zx5.val", 64'(bus32.imm_out), 64'h0000_001F);
    bus.instr_in = 16'h0400; bus.imm_size = 2'b10; bus.zero_ex = 0;
    cycle("imm_sx11");
    chk("imm_sx11.val", 64'(bus.imm_out), 64'hFC00);
    bus.instr_in = 16'h0080; bus.imm_size = 2'b01;
    cycle("imm_sx8");
    chk("imm_sx8.val", 64'(bus.imm_out), 64'hFF80);
    bus.imm_size = 2'b00;

    // Bubble vs squash
    bus.stall = 1; bus.reg_write_in = 1; bus.mem_write_in = 1; bus.pc2_in = 16'h0012;
    cycle("stall");
    chk("stall.rw", 64'(bus.reg_write_out), 64'd0);
    chk("stall.mw", 64'(bus.mem_write_out), 64'd0);
    chk("stall.valid", 64'(bus.valid_out), 64'd0);
    chk("stall.pc2", 64'(bus.pc2_out), 64'h0012);
    bus.stall = 0; bus.flush = 1;
    cycle("flush");
    chk("flush.rw", 64'(bus.reg_write_out), 64'd0);
    chk("flush.mw", 64'(bus.mem_write_out), 64'd0);
    chk("flush.valid", 64'(bus.valid_out), 64'd0);
    chk("flush.pc2", 64'(bus.pc2_out), 64'h0012);
    bus.flush = 0;
    bus.instr_in = 16'h0765; bus.pc2_in = 16'h0100; bus.ctrl_in = 15'h1ABC;
    cycle("pre_hold");
    chk("pre_hold.valid", 64'(bus.valid_out), 64'd1);

    // Hold beats flush and stall; write-back still lands
    snap = cur;
    bus.hold = 1; bus.flush = 1; bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      bus.wb_en = (k == 2);
      bus.wb_addr = 3'd5; bus.wb_data = 16'h5A5A;
      cycle("hold");
      chk("hold.pc2", 64'(bus.pc2_out), snap.pc2);
      chk("hold.valid", 64'(bus.valid_out), 64'd1);
    end
    set_idle();
    bus.instr_in = 16'h0500;
    cycle("after_hold");
    chk("after_hold.rd1", 64'(bus.rd1_out), 64'h5A5A);

    // Destination select
    bus.reg_dst = 2'b11;
    cycle("dst_link");
    chk("dst_link.wr", 64'(bus.wr_addr_out), 64'd7);
    bus.reg_dst = 2'b01; bus.instr_in = 16'h0014;
    cycle("dst_rt");
    chk("dst_rt.wr", 64'(bus.wr_addr_out), 64'd5);

    // Error flag
    bus.reg_dst = 2'b00; bus.imm_size = 2'b11; bus.stall = 1;
    cycle("err_stall");
    chk("err_stall.err", 64'(bus.err), 64'd0);
    bus.stall = 0;
    cycle("err_set");
    chk("err_set.err", 64'(bus.err), 64'd1);
    chk("err_set.imm", 64'(bus.imm_out), 64'd0);
    bus.imm_size = 2'b00;
    for (int k = 0; k < 5; k++) begin
      cycle("err_sticky");
      chk("err_sticky.err", 64'(bus.err), 64'd1);
    end
    #2 rst = 1'b0;
    #1 model_reset();
    chk("err_reset.err", 64'(bus.err), 64'd0);
    check_all("err_reset");
    #1 rst = 1'b1;

    // Randomized run against the model
    for (int k = 0; k < 300; k++) begin
      rand_data();
      if ($urandom_range(0, 19) == 0) bus.imm_size = 2'b11;
      bus.hold  = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      bus.stall = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
